// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, lane indices and lane pack/unpack helpers for pipeline stages.
package pipe_pkg;
    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_NUM_CH = 6;
    localparam int PIPE_CNT_W  = 32;
    localparam logic [PIPE_DATA_W-1:0] PIPE_NOP = '0;
    localparam int LN_INSTR = 0;
    localparam int LN_PC    = 1;
    localparam int LN_RD2   = 2;
    localparam int LN_EXT   = 3;
    localparam int LN_AO    = 4;
    localparam int LN_MDUO  = 5;
    typedef logic [PIPE_DATA_W-1:0] lane_t;
    typedef logic [PIPE_NUM_CH*PIPE_DATA_W-1:0] bus_t;
    function automatic lane_t lane_get(input bus_t b, input int k);
        return b[k*PIPE_DATA_W +: PIPE_DATA_W];
    endfunction
    function automatic bus_t lane_put(input bus_t b, input int k, input lane_t v);
        bus_t r;
        r = b;
        r[k*PIPE_DATA_W +: PIPE_DATA_W] = v;
        return r;
    endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one stage entry (valid + payload); clear wins over load and zeroes the payload.
module pipe_slot #(
    parameter int W = 192
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] d_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        valid_d = clear_i ? 1'b0 : (load_i ? 1'b1 : valid_q);
        data_d  = clear_i ? '0 : (load_i ? d_i : data_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a one-entry skid buffer and sync flush.
// Optional perf counters (stall/bubble) are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int NUM_CH = PIPE_NUM_CH
`ifdef PIPE_STAGE_PERF_EN
    ,
    parameter int CNT_W  = PIPE_CNT_W
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [NUM_CH*DATA_W-1:0] out_data_o
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         bubble_cnt_o
`endif
);
    localparam int W = NUM_CH * DATA_W;

    logic         main_v, skid_v;
    logic [W-1:0] main_data, skid_data, main_src;
    logic         in_fire, out_fire, main_adv;
    logic         main_ld, main_clr, skid_ld, skid_clr;

    assign in_ready_o = !skid_v;
    assign in_fire    = in_valid_i & in_ready_o;
    assign out_fire   = main_v & out_ready_i;
    // main may take a new entry when it is empty or draining this cycle
    assign main_adv   = !main_v | out_fire;

    always_comb begin
        main_src = skid_v ? skid_data : in_data_i;
        main_ld  = !flush_i & main_adv & (skid_v | in_fire);
        main_clr = flush_i | (main_adv & !skid_v & !in_fire);
        skid_ld  = !flush_i & in_fire & (!main_adv | skid_v);
        skid_clr = flush_i | (main_adv & !(skid_v & in_fire));
    end

    pipe_slot #(.W(W)) u_main (
        .clk(clk), .rst_n(rst_n), .load_i(main_ld), .clear_i(main_clr),
        .d_i(main_src), .valid_o(main_v), .data_o(main_data)
    );

    pipe_slot #(.W(W)) u_skid (
        .clk(clk), .rst_n(rst_n), .load_i(skid_ld), .clear_i(skid_clr),
        .d_i(in_data_i), .valid_o(skid_v), .data_o(skid_data)
    );

    assign out_valid_o = main_v;
    assign out_data_o  = main_data;

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

    // saturating counters; flush deliberately leaves them alone
    always_comb begin
        stall_d  = stall_q + CNT_W'(main_v & !out_ready_i & ~&stall_q);
        bubble_d = bubble_q + CNT_W'(!main_v & ~&bubble_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign bubble_cnt_o = bubble_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scenario tasks plus a scoreboard that tracks every accepted word in FIFO order.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int W = PIPE_NUM_CH * PIPE_DATA_W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [PIPE_CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q[$];

    pipe_stage_skid dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] mk(input int i);
        bus_t b;
        b = '0;
        for (int k = 0; k < PIPE_NUM_CH; k++) b = lane_put(b, k, lane_t'(i * 256 + k + 1));
        return b;
    endfunction

    // scoreboard: push on accept, pop on delivery; flush or reset drops everything held
    always @(posedge clk or negedge rst_n) begin
        logic [W-1:0] exp;
        if (!rst_n) sb_q.delete();
        else if (flush) sb_q.delete();
        else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got lane0 %h, expected no output", lane_get(out_data, LN_INSTR));
                end else begin
                    exp = sb_q.pop_front();
                    if (out_data !== exp) begin
                        errors++;
                        $display("FAIL sb_order: got lane0 %h, expected %h", lane_get(out_data, LN_INSTR), lane_get(exp, LN_INSTR));
                    end
                end
            end
            if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    task automatic check_idle(input string tag);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: out_valid=%b out_data_nz=%b in_ready=%b, expected 0 0 1", tag, out_valid, |out_data, in_ready);
        end
    endtask

    task automatic check_out(input string tag, input logic [W-1:0] exp, input logic exp_rdy);
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp || in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL %s: out_valid=%b lane0=%h in_ready=%b, expected 1 %h %b", tag, out_valid, lane_get(out_data, LN_INSTR), in_ready, lane_get(exp, LN_INSTR), exp_rdy);
        end
    endtask

    task automatic check_empty_sb(input string tag);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d words outstanding, expected 0", tag, sb_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_idle("reset_init");
        rst_n = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = mk(50);
        @(negedge clk);
        in_data = mk(51);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("reset_prefill", mk(50), 1'b0);
        #2 rst_n = 1'b0;
        #1 check_idle("reset_async");
        @(negedge clk);
        check_idle("reset_held");
        rst_n = 1'b1;
        check_empty_sb("reset_sb");
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) check_out($sformatf("stream_%0d", i), mk(i), 1'b1);
            else check_idle("stream_start");
            in_valid = (i < 8);
            in_data = (i < 8) ? mk(i + 1) : '0;
        end
        @(negedge clk);
        check_idle("stream_end");
        check_empty_sb("stream_sb");
    endtask

    task automatic fill_ab(input int a, input int b);
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = mk(a);
        @(negedge clk);
        check_out("fill_a", mk(a), 1'b1);
        in_data = mk(b);
        @(negedge clk);
        check_out("fill_b", mk(a), 1'b0);
    endtask

    task automatic test_backpressure();
        fill_ab(10, 11);
        in_data = mk(12);
        @(negedge clk);
        check_out("bp_hold", mk(10), 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check_out("bp_b", mk(11), 1'b1);
        @(negedge clk);
        check_out("bp_c", mk(12), 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("bp_drained");
        check_empty_sb("bp_sb");
    endtask

    task automatic test_flush_full();
        fill_ab(20, 21);
        in_data = mk(22);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check_idle("flush_full");
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("flush_no_c");
        end
        check_empty_sb("flush_sb");
    endtask

    task automatic test_flush_vs_ready();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = mk(30);
        @(negedge clk);
        check_out("fvr_load", mk(30), 1'b1);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle("fvr_flush");
        @(negedge clk);
        check_idle("fvr_after");
        check_empty_sb("fvr_sb");
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        logic [PIPE_CNT_W-1:0] b;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall_cnt !== '0 || bubble_cnt !== '0) begin
            errors++;
            $display("FAIL perf_reset: stall=%0d bubble=%0d, expected 0 0", stall_cnt, bubble_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = mk(40);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (stall_cnt !== 32'd3 || bubble_cnt < 32'd2) begin
            errors++;
            $display("FAIL perf_count: stall=%0d bubble=%0d, expected 3 and >=2", stall_cnt, bubble_cnt);
        end
        b = bubble_cnt;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (stall_cnt !== 32'd3 || bubble_cnt < b) begin
            errors++;
            $display("FAIL perf_flush: stall=%0d bubble=%0d, expected 3 and >=%0d", stall_cnt, bubble_cnt, b);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush_full();
        test_flush_vs_ready();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
